// File: rtl/robertsons_controller.sv
// Sequencing FSM for the Robertson signed multiplier datapath.
// Optional `ROBERTSONS_FUSED_SHIFT_EN: shift zero bits directly from TEST.
module robertsons_controller #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q0,
  output logic             load,
  output logic             add,
  output logic             sub,
  output logic             shift_en,
  output logic             shift_mode,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  if (WIDTH < 2 || WIDTH > 64 || (2 ** CNT_W) <= WIDTH) begin : g_bad_cfg
    $error("robertsons_controller: illegal WIDTH/CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ARITH,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    load       = 1'b0;
    add        = 1'b0;
    sub        = 1'b0;
    shift_en   = 1'b0;
    shift_mode = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          iter_d  = '0;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_TEST;
      end
      S_TEST: begin
        if (q0) begin
          state_d = S_ARITH;
        end else begin
`ifdef ROBERTSONS_FUSED_SHIFT_EN
          shift_en = 1'b1;
          iter_d   = iter_q + CNT_W'(1);
          state_d  = (iter_q == LAST) ? S_DONE : S_TEST;
`else
          state_d = S_SHIFT;
`endif
        end
      end
      S_ARITH: begin
        // Final iteration weighs the sign bit negatively.
        add     = (iter_q != LAST);
        sub     = (iter_q == LAST);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        iter_d   = iter_q + CNT_W'(1);
        state_d  = (iter_q == LAST) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Strobes stay quiet while reset is held, even mid-operation.
    if (reset) begin
      load     = 1'b0;
      add      = 1'b0;
      sub      = 1'b0;
      shift_en = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

  assign iter = iter_q;

endmodule

// File: doc/robertsons_controller.md
Name: robertsons_controller

Overview:
- Sequencing FSM for the Robertson signed (two's-complement) multiplier datapath.
- Accepts a start request and steps the accumulator/multiplier datapath through WIDTH iterations. Each iteration runs an optional add (or subtract on the final, sign-bit iteration), then an arithmetic right shift.
- Observes only the multiplier LSB from the datapath and drives load/add/sub/shift strobes plus a busy/done handshake to the surrounding top level.

Parameters:
- WIDTH, 16: operand width in bits; number of iterations per multiply. Legal range 2..64.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- q0  input  1  current LSB of the datapath multiplier register
- load  output  1  load operands into datapath; clear accumulator
- add  output  1  accumulator <= accumulator + multiplicand
- sub  output  1  accumulator <= accumulator - multiplicand (final iteration only)
- shift_en  output  1  enable the arithmetic right shift of {accumulator, multiplier}
- shift_mode  output  1  shift mode to datapath; always 0 (arithmetic)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: product is valid in the datapath
- iter  output  CNT_W  number of iterations completed in the current multiply

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk and reset).
- States: IDLE, LOAD, TEST, ARITH, SHIFT, DONE. State register and iteration counter are the only flops.
- Outputs are Moore decodes of the state register, except as noted under the optional feature.
- Reset:
  - Sets state to IDLE and iter to 0.
  - All outputs are 0 during and after reset.
  - Reset asserted mid-operation aborts the multiply immediately; no done pulse is issued.
- IDLE:
  - start=1 -> LOAD, and iter <= 0.
  - start=0 -> stay in IDLE.
- LOAD: load=1 for exactly one cycle -> TEST.
- TEST: examines q0 (datapath is stable in this cycle).
  - q0=1 -> ARITH.
  - q0=0 -> SHIFT.
- ARITH: one cycle -> SHIFT.
  - iter < WIDTH-1 -> add=1.
  - iter == WIDTH-1 -> sub=1 (sign-bit correction).
  - add and sub are never high together.
- SHIFT: shift_en=1 and iter <= iter+1.
  - If iter (pre-increment) == WIDTH-1 -> DONE.
  - Otherwise -> TEST.
- DONE: done=1 for one cycle -> IDLE unconditionally.
  - start is not sampled in DONE.
  - If start stays high, the next multiply begins on the cycle after the return to IDLE.
- busy: 1 in LOAD, TEST, ARITH, SHIFT and DONE.
- start while busy: ignored; no queuing.
- Latency from the start-sampling edge to done high:
  - 1 (LOAD) + 2 per zero multiplier bit + 3 per one bit + 1.
  - Best case 2*WIDTH+2 cycles; worst case 3*WIDTH+2 cycles.
- iter:
  - Holds its final value WIDTH through DONE and IDLE.
  - Cleared only by a new start or by reset.
- shift_mode is tied 0 in all states.

Optional Feature:
- Macro: ROBERTSONS_FUSED_SHIFT_EN.
- Defined:
  - In TEST with q0=0, shift_en=1 combinationally (Mealy output) and iter increments in the same cycle.
  - The next state is TEST, or DONE if this was the final iteration; SHIFT is skipped.
  - Zero bits therefore cost 1 cycle. Best-case latency becomes WIDTH+2.
  - q0=1 behaviour is unchanged.
- Not defined:
  - All outputs are pure Moore decodes.
  - Zero bits cost 2 cycles as above.

Test Plan:
1. WIDTH=4, multiplier 4'b0000 (unfused).
   - Expect: load in cycle 1, then 4×(TEST, SHIFT).
   - add/sub never asserted; done in cycle 10 after start sampled; iter=4.
2. WIDTH=4, multiplier 4'b1111, multiplicand 3 (bench datapath model).
   - Expect: add asserted 3 times, sub once (final iteration); done in cycle 14.
   - Model product = -3.
3. WIDTH=4, multiplier 4'b0101, multiplicand -2.
   - Expect: add in iterations 0 and 2; no sub.
   - Product = -10; done after 12 cycles.
4. start held high continuously.
   - Expect: done pulses exactly 1 cycle wide, each followed by one IDLE cycle (busy=0) before the next LOAD.
   - start pulses during busy have no effect.
5. reset asserted in the ARITH state of iteration 2.
   - Expect: next cycle state IDLE, all outputs 0, iter=0, no done pulse.
   - A fresh start then completes normally.
6. ROBERTSONS_FUSED_SHIFT_EN defined, WIDTH=4, multiplier 4'b0000.
   - Expect: shift_en high in 4 consecutive TEST cycles; done in cycle 6.
   - Multiplier 4'b1111 timing is identical to scenario 2.
